gray_conv_scheduler: RTL and testbench



---
 rtl/gray_sched_pkg.sv | 25 ++
 rtl/gray_rr_arbiter.sv | 39 +++
 rtl/gray_conv_scheduler.sv | 105 ++++++++++
 tb/tb_gray_conv_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_sched_pkg.sv
// Shared types and helpers for the round-robin gray-to-binary scheduler.
package gray_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 8;
    localparam int REF_MAXW = 64;

    // Reference conversion on a zero-extended word: the upper zero bits leave
    // the low W result bits unchanged, so any W up to REF_MAXW is covered.
    function automatic logic [REF_MAXW-1:0] gray2bin_ref(input logic [REF_MAXW-1:0] g);
        logic [REF_MAXW-1:0] b;
        b[REF_MAXW-1] = g[REF_MAXW-1];
        for (int k = REF_MAXW - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or after ptr wins.
module gray_rr_arbiter
    import gray_sched_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        sum       = '0;
        idx       = '0;
        found     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/gray_conv_scheduler.sv
// Shares one external gray-to-binary converter among NREQ requesters.
// Optional converter cross-check enabled by defining GRAY_SCHED_CHECK_EN.
module gray_conv_scheduler
    import gray_sched_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    parameter  int W    = DEF_W,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_gray,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      conv_gray,
    input  logic [W-1:0]      conv_bin,
    output logic              res_valid,
    output logic [W-1:0]      res_bin,
    output logic [IDW-1:0]    res_id,
    input  logic              res_ready,
    output logic              err
);

    sched_state_e   state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] op_id;
    logic [W-1:0]   op_gray;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] next_ptr;
    logic           arb_en;

    // Grants are suppressed while reset is asserted so nothing is accepted that cycle.
    assign arb_en    = (state == IDLE) && !rst;
    assign req_ready = grant;
    assign conv_gray = op_gray;
    assign next_ptr  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

    gray_rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_gray   <= '0;
            op_id     <= '0;
            res_valid <= 1'b0;
            res_bin   <= '0;
            res_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        op_gray <= req_gray[grant_idx*W +: W];
                        op_id   <= grant_idx;
                        rr_ptr  <= next_ptr;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    res_bin   <= conv_bin;
                    res_id    <= op_id;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GRAY_SCHED_CHECK_EN
    logic [W-1:0] ref_bin;
    logic         err_q;

    assign ref_bin = W'(gray2bin_ref(REF_MAXW'(op_gray)));

    // Sticky until reset; the converter's answer is still forwarded as-is.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == CONV && conv_bin != ref_bin) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_conv_scheduler.sv
// Scoreboard bench for gray_conv_scheduler; honours GRAY_SCHED_CHECK_EN.
module tb_gray_conv_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_gray;
    logic [3:0]  req_ready;
    logic [7:0]  conv_gray;
    logic [7:0]  conv_bin;
    logic        res_valid;
    logic [7:0]  res_bin;
    logic [1:0]  res_id;
    logic        res_ready;
    logic        err;
    logic        fault_en;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] bin;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

`ifdef GRAY_SCHED_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    localparam logic [7:0] SWEEP_G[5] = '{8'h00, 8'h01, 8'h03, 8'h06, 8'h80};
    localparam logic [7:0] SWEEP_B[5] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'hFF};
    localparam int         RR_ORDER[6] = '{0, 1, 2, 3, 0, 1};
    localparam logic [7:0] RR_BIN[4]   = '{8'h08, 8'h01, 8'h02, 8'h04};

    always #5 clk = ~clk;

    // External converter model, with a single-bit fault injectable for gray 0C.
    function automatic logic [7:0] g2b(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int k = 6; k >= 0; k--) b[k] = b[k+1] ^ g[k];
        return b;
    endfunction

    assign conv_bin = g2b(conv_gray) ^ ((fault_en && conv_gray == 8'h0C) ? 8'h01 : 8'h00);

    gray_conv_scheduler #(
        .NREQ(4),
        .W(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_gray  (req_gray),
        .req_ready (req_ready),
        .conv_gray (conv_gray),
        .conv_bin  (conv_bin),
        .res_valid (res_valid),
        .res_bin   (res_bin),
        .res_id    (res_id),
        .res_ready (res_ready),
        .err       (err)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s actual=timeout required=event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input int id, input logic [7:0] bin);
        exp_t e;
        e.id  = 2'(id);
        e.bin = bin;
        exp_q.push_back(e);
    endtask

    task automatic setGray(input int idx, input logic [7:0] g);
        req_gray[idx*8 +: 8] = g;
    endtask

    task automatic doReset();
        rst       = 1'b1;
        req_valid = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Present mask, wait for a grant, check the winner and queue its expected result.
    task automatic applyStimulus(input logic [3:0] mask, input int winner, input logic [7:0] exp_bin);
        bit got = 1'b0;
        req_valid = mask;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            failNow("grant_wait");
        end else begin
            checkOutput("grant", 32'(req_ready), 32'(1) << winner);
            pushExp(winner, exp_bin);
        end
        tick();
        req_valid = 4'b0000;
    endtask

    task automatic waitDrain(input string name);
        bit done = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) failNow(name);
    endtask

    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_result actual id=%0d bin=%h required=none", res_id, res_bin);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("res_id", 32'(res_id), 32'(mon_e.id));
                checkOutput("res_bin", 32'(res_bin), 32'(mon_e.bin));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_gray  = '0;
        res_ready = 1'b1;
        fault_en  = 1'b0;

        tick();
        @(negedge clk);
        checkOutput("ready_in_reset", 32'(req_ready), 32'd0);
        tick();
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_res_bin", 32'(res_bin), 32'd0);
        checkOutput("rst_res_id", 32'(res_id), 32'd0);
        checkOutput("rst_conv_gray", 32'(conv_gray), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        req_valid = 4'b0000;
        rst       = 1'b0;
        tick();

        $display("[TB] single request");
        setGray(0, 8'h0C);
        applyStimulus(4'b0001, 0, 8'h08);
        checkOutput("t1_ready_in_conv", 32'(req_ready), 32'd0);
        checkOutput("t1_valid_in_conv", 32'(res_valid), 32'd0);
        tick();
        checkOutput("t1_latency", 32'(res_valid), 32'd1);
        waitDrain("t1_drain");
        checkOutput("t1_err_clean", 32'(err), 32'd0);

        $display("[TB] conversion sweep");
        for (int i = 0; i < 5; i++) begin
            setGray(2, SWEEP_G[i]);
            applyStimulus(4'b0100, 2, SWEEP_B[i]);
            waitDrain("t2_drain");
        end

        $display("[TB] round robin");
        doReset();
        for (int i = 0; i < 4; i++) setGray(i, (i == 0) ? 8'h0C : (i == 1) ? 8'h01 : (i == 2) ? 8'h03 : 8'h06);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            bit got = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (req_ready != 4'b0000) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                failNow("t3_grant_wait");
            end else begin
                checkOutput("t3_rr_grant", 32'(req_ready), 32'(1) << RR_ORDER[k]);
                pushExp(RR_ORDER[k], RR_BIN[RR_ORDER[k]]);
            end
            tick();
            if (k == 5) req_valid = 4'b0000;
        end
        waitDrain("t3_drain");
        applyStimulus(4'b0001, 0, 8'h08);
        waitDrain("t3_drain_b");
        applyStimulus(4'b1001, 3, 8'h04);
        waitDrain("t3_drain_c");

        $display("[TB] backpressure");
        res_ready = 1'b0;
        setGray(1, 8'h80);
        setGray(2, 8'h06);
        applyStimulus(4'b0110, 1, 8'hFF);
        req_valid = 4'b0100;
        tick();
        checkOutput("t4_valid_rise", 32'(res_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("t4_hold", 32'({res_valid, res_bin, res_id, req_ready}), 32'({1'b1, 8'hFF, 2'd1, 4'b0000}));
        end
        tick();
        res_ready = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("t4_next_grant", 32'(req_ready), 32'b0100);
        pushExp(2, 8'h04);
        tick();
        req_valid = 4'b0000;
        waitDrain("t4_drain");

        $display("[TB] reset mid-operation");
        setGray(0, 8'h0C);
        setGray(1, 8'h01);
        req_valid = 4'b0011;
        @(negedge clk);
        checkOutput("t5_first_grant", 32'(req_ready), 32'b0001);
        tick();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_ready_in_reset", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        checkOutput("t5_valid_cleared", 32'(res_valid), 32'd0);
        @(negedge clk);
        checkOutput("t5_regrant", 32'(req_ready), 32'b0001);
        pushExp(0, 8'h08);
        tick();
        applyStimulus(4'b0010, 1, 8'h01);
        waitDrain("t5_drain");

        $display("[TB] converter check");
        fault_en = 1'b1;
        setGray(0, 8'h0C);
        applyStimulus(4'b0001, 0, 8'h09);
        waitDrain("t6_drain");
        fault_en = 1'b0;
        checkOutput("t6_err_set", 32'(err), 32'(ERR_EXP));
        setGray(1, 8'h03);
        applyStimulus(4'b0010, 1, 8'h02);
        waitDrain("t6_drain_b");
        checkOutput("t6_err_sticky", 32'(err), 32'(ERR_EXP));
        doReset();
        checkOutput("t6_err_cleared", 32'(err), 32'd0);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL leftover_expected actual=%0d required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
